rle_block_decoder: RTL

//  Decoder-side counterpart of the Huffman DC/AC encoder output stage: consumes decoded (run,size,amplitude-bits)

---
 rtl/rle_block_decoder_if.sv | 36 +++
 rtl/rle_block_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rle_block_decoder_if.sv
// Symbol-in / block-out bundle between the Huffman symbol decoder and the block decoder.
// Latency: none, this is wiring only.
// Backpressure: sym_valid/sym_ready on the symbol side, blk_valid/blk_ready on the block side.
interface rle_block_decoder_if #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 64
);
    // decoded symbol stream
    logic                          sym_valid;
    logic                          sym_ready;
    logic                          sym_is_dc;
    logic [1:0]                    sym_comp;
    logic [3:0]                    sym_run;
    logic [3:0]                    sym_size;
    logic [10:0]                   sym_bits;
    logic                          pred_clear;

    // rebuilt coefficient block, coef k at [DATA_WIDTH*k +: DATA_WIDTH]
    logic                          blk_valid;
    logic                          blk_ready;
    logic [DATA_WIDTH*DEPTH-1:0]   blk_coeffs;
    logic [1:0]                    blk_comp;
    logic                          err_pulse;

    // symbol producer / block consumer side
    modport master (
        output sym_valid, sym_is_dc, sym_comp, sym_run, sym_size, sym_bits, pred_clear, blk_ready,
        input  sym_ready, blk_valid, blk_coeffs, blk_comp, err_pulse
    );

    // decoder side
    modport slave (
        input  sym_valid, sym_is_dc, sym_comp, sym_run, sym_size, sym_bits, pred_clear, blk_ready,
        output sym_ready, blk_valid, blk_coeffs, blk_comp, err_pulse
    );
endinterface

// File: rtl/rle_block_decoder.sv
// Rebuilds one zigzag-ordered block of signed coefficients from (run,size,bits) symbols with DC prediction.
// Latency: blk_valid rises the cycle after the terminating symbol (EOB, last write/ZRL, or overrun) is accepted.
// Backpressure: sym_ready drops while a finished block waits for blk_ready; one bubble cycle between blocks.
module rle_block_decoder #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 64,
    parameter int NUM_COMP   = 3
) (
    input  logic              clock,
    input  logic              reset,
    rle_block_decoder_if.slave bus
);
    // idx runs 0..DEPTH inclusive, so it needs one value more than an address
    localparam int IW = $clog2(DEPTH + 1);
    // target arithmetic (idx + run, idx + 16) can exceed DEPTH before the range check
    localparam int TW = IW + 1;
    localparam int AW = $clog2(DEPTH);
    // predictor (DATA_WIDTH) + 13-bit amplitude never overflows 14 bits
    localparam int SW = 14;

    localparam logic [TW-1:0]        DEPTH_T  = TW'(DEPTH);
    localparam logic [TW-1:0]        ZRL_STEP = TW'(16);
    localparam logic signed [SW-1:0] COEF_MAX = SW'((1 <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] COEF_MIN = -COEF_MAX - 14'sd1;

    typedef enum logic [1:0] {
        S_DC  = 2'd0,
        S_AC  = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [IW-1:0]                          idx_q, idx_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]       coef_q, coef_d;
    logic [NUM_COMP-1:0][DATA_WIDTH-1:0]    pred_q, pred_d;
    logic [1:0]                             comp_q, comp_d;
    logic                                   blk_valid_q, blk_valid_d;
    logic                                   sym_ready_q, sym_ready_d;
    logic                                   err_q, err_d;

    logic                                   accept;
    logic signed [12:0]                     amp;
    logic [DATA_WIDTH-1:0]                  pred_base;
    logic [DATA_WIDTH-1:0]                  dc_val;
    logic [TW-1:0]                          tgt;
    logic [TW-1:0]                          nxt;
    logic [TW-1:0]                          zrl;

    // JPEG-style amplitude: leading bit 1 means positive, else value is bits - (2^size - 1)
    function automatic logic signed [12:0] amp_decode(input logic [3:0] size, input logic [10:0] bits);
        logic [15:0] mask;
        logic [15:0] val;
        mask = (16'd1 << size) - 16'd1;
        val  = {5'd0, bits} & mask;
        if (size == 4'd0) begin
            amp_decode = '0;
        end else if (val[size - 4'd1]) begin
            amp_decode = val[12:0];
        end else begin
            amp_decode = 13'(val - mask);
        end
    endfunction

    // clamp a wide signed value into the coefficient range
    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > COEF_MAX) begin
            sat = COEF_MAX[DATA_WIDTH-1:0];
        end else if (v < COEF_MIN) begin
            sat = COEF_MIN[DATA_WIDTH-1:0];
        end else begin
            sat = v[DATA_WIDTH-1:0];
        end
    endfunction

    assign accept = bus.sym_valid & sym_ready_q;
    assign amp    = amp_decode(bus.sym_size, bus.sym_bits);

    // next-state: symbol interpretation, coefficient/predictor updates, error detection
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        coef_d    = coef_q;
        pred_d    = pred_q;
        comp_d    = comp_q;
        err_d     = 1'b0;
        pred_base = '0;
        dc_val    = '0;
        tgt       = TW'(idx_q) + TW'(bus.sym_run);
        nxt       = tgt + TW'(1);
        zrl       = TW'(idx_q) + ZRL_STEP;

        // a restart clears every predictor; a coincident DC below sees zero and overwrites its own
        if (bus.pred_clear) begin
            pred_d = '0;
        end

        case (state_q)
            S_DC: begin
                if (accept) begin
                    // DC size above 11 cannot be produced by a legal stream, so it is treated like a bad id
                    if (!bus.sym_is_dc || int'(bus.sym_comp) >= NUM_COMP || bus.sym_size > 4'd11) begin
                        err_d = 1'b1;
                    end else begin
                        pred_base              = bus.pred_clear ? '0 : pred_q[bus.sym_comp];
                        dc_val                 = sat(SW'(signed'(pred_base)) + SW'(amp));
                        coef_d                 = '0;
                        coef_d[0]              = dc_val;
                        pred_d[bus.sym_comp]   = dc_val;
                        comp_d                 = bus.sym_comp;
                        idx_d                  = IW'(1);
                        state_d                = S_AC;
                    end
                end
            end

            S_AC: begin
                if (accept) begin
                    if (bus.sym_is_dc || bus.sym_size > 4'd10) begin
                        err_d = 1'b1;
                    end else if (bus.sym_size == 4'd0) begin
                        if (bus.sym_run == 4'd0) begin
                            // EOB: rest of the block is already zero
                            state_d = S_OUT;
                        end else if (bus.sym_run == 4'd15) begin
                            // ZRL: sixteen zeros, must not run past the block end
                            if (zrl > DEPTH_T) begin
                                err_d   = 1'b1;
                                state_d = S_OUT;
                            end else begin
                                idx_d = zrl[IW-1:0];
                                if (zrl == DEPTH_T) begin
                                    state_d = S_OUT;
                                end
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        // run zeros then one nonzero coefficient; overrun closes the block as-is
                        if (tgt >= DEPTH_T) begin
                            err_d   = 1'b1;
                            state_d = S_OUT;
                        end else begin
                            coef_d[tgt[AW-1:0]] = sat(SW'(amp));
                            idx_d               = nxt[IW-1:0];
                            if (nxt == DEPTH_T) begin
                                state_d = S_OUT;
                            end
                        end
                    end
                end
            end

            S_OUT: begin
                if (bus.blk_ready) begin
                    state_d = S_DC;
                end
            end

            default: begin
                state_d = S_DC;
            end
        endcase

        blk_valid_d = (state_d == S_OUT);
        sym_ready_d = (state_d != S_OUT);
    end

    // all state and outputs registered; reset discards any partial block
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_DC;
            idx_q       <= '0;
            coef_q      <= '0;
            pred_q      <= '0;
            comp_q      <= '0;
            blk_valid_q <= 1'b0;
            sym_ready_q <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            coef_q      <= coef_d;
            pred_q      <= pred_d;
            comp_q      <= comp_d;
            blk_valid_q <= blk_valid_d;
            sym_ready_q <= sym_ready_d;
            err_q       <= err_d;
        end
    end

    assign bus.sym_ready  = sym_ready_q;
    assign bus.blk_valid  = blk_valid_q;
    assign bus.blk_coeffs = coef_q;
    assign bus.blk_comp   = comp_q;
    assign bus.err_pulse  = err_q;
endmodule
